// File: rtl/sramlike_arbiter.sv
// sramlike_arbiter: two-master (inst, data) to one-slave sram-like arbiter.
// One transaction in flight at a time; ownership held from request to data_ok.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   inst_* / data_*               master request side, handshakes and rdata back
//   bus_*                         shared slave side (AXI bridge)
//   owner                         current/last owner (0 = inst, 1 = data)
//   arb_err                       sticky slave protocol-error flag
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie-break
// (default: data wins every tie).
module sramlike_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          inst_req,
    input  logic          inst_wr,
    input  logic [1:0]    inst_size,
    input  logic [AW-1:0] inst_addr,
    input  logic [DW-1:0] inst_wdata,
    output logic [DW-1:0] inst_rdata,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,

    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic [DW-1:0] data_rdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,

    output logic          bus_req,
    output logic          bus_wr,
    output logic [1:0]    bus_size,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_addr_ok,
    input  logic          bus_data_ok,

    output logic          owner,
    output logic          arb_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT
    } state_t;

    state_t state_q;
    logic   owner_q;
    logic   err_q;

    logic   any_req;
    logic   tie_win;
    logic   win;
    logic   sel;
    logic   sel_req;
    logic   drive;
    logic   in_wait;
    logic   err_set;

`ifdef ARB_ROUND_ROBIN_EN
    // Last granted master; the other one wins the next tie.
    logic   last_q;
    assign tie_win = ~last_q;
`else
    assign tie_win = 1'b1;
`endif

    assign any_req = inst_req | data_req;
    assign win     = (inst_req & data_req) ? tie_win : data_req;

    // In IDLE the fresh winner drives the bus; afterwards the latched owner.
    assign sel     = (state_q == S_IDLE) ? win : owner_q;
    assign sel_req = sel ? data_req : inst_req;
    assign drive   = (state_q != S_WAIT) & sel_req;
    assign in_wait = (state_q == S_WAIT);

    assign bus_req   = drive;
    assign bus_wr    = drive & (sel ? data_wr : inst_wr);
    assign bus_size  = drive ? (sel ? data_size  : inst_size)  : '0;
    assign bus_addr  = drive ? (sel ? data_addr  : inst_addr)  : '0;
    assign bus_wdata = drive ? (sel ? data_wdata : inst_wdata) : '0;

    assign inst_addr_ok = bus_addr_ok & drive & ~sel;
    assign data_addr_ok = bus_addr_ok & drive & sel;
    assign inst_data_ok = bus_data_ok & in_wait & ~owner_q;
    assign data_data_ok = bus_data_ok & in_wait & owner_q;

    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;

    assign owner   = owner_q;
    assign arb_err = err_q;

    // data_ok outside WAIT, or addr_ok with nothing offered, is a slave bug.
    assign err_set = (bus_data_ok & ~in_wait) | (bus_addr_ok & ~drive);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            if (err_set) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        owner_q <= win;
`ifdef ARB_ROUND_ROBIN_EN
                        last_q  <= win;
`endif
                        state_q <= bus_addr_ok ? S_WAIT : S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bus_addr_ok & drive) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus_data_ok) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
